// File: rtl/syncro_sched_pkg.sv
// Shared types and defaults for the syncro word scheduler.
package syncro_sched_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 4;
  localparam int unsigned DW_DEFAULT      = 32;
  localparam int unsigned SETTLE_DEFAULT  = 3;
  localparam int unsigned MAX_RETRY       = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/syncro_word_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IW-1:0]      grant_idx,
  output logic               valid
);

  int unsigned idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    valid        = 1'b0;
    idx          = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid             = 1'b1;
        grant_idx         = IW'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/syncro_word_sched.sv
// Round-robin scheduler sharing one syncro32 crossing among NUM_REQ requesters.
// Optional SYNC_READBACK_EN: verify syncro output before ack, retry up to MAX_RETRY.
module syncro_word_sched
  import syncro_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned SETTLE  = SETTLE_DEFAULT
) (
  input  logic                       clk_clkin,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DW-1:0]      data_in,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DW-1:0]              sync_data,
  output logic                       sync_wr_en,
  input  logic [DW-1:0]              sync_rdback,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  sched_state_t       state;
  logic [IW-1:0]      ptr;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_valid;
  logic               can_grant;
  logic [DW-1:0]      sel_word;
  logic [IW-1:0]      ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req          (req),
    .ptr          (ptr),
    .grant_onehot (gnt_onehot),
    .grant_idx    (gnt_idx),
    .valid        (gnt_valid)
  );

  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_onehot[i]) sel_word = sel_word | data_in[i*DW +: DW];
    end
  end

  assign ptr_next = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef SYNC_READBACK_EN
  logic [RW-1:0] retry;
  logic          rd_match;

  assign rd_match = (sync_rdback == sync_data);
  // Ack lands in IDLE here, so hold off one cycle to let the requester drop req.
  assign can_grant = gnt_valid && (ack == '0);

  always_ff @(posedge clk_clkin) begin
    if (reset) begin
      state      <= ST_IDLE;
      sync_data  <= '0;
      sync_wr_en <= 1'b1;
      ack        <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      err        <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
      retry      <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          sync_wr_en <= 1'b1;
          if (can_grant) begin
            grant_id   <= gnt_idx;
            sync_data  <= sel_word;
            sync_wr_en <= 1'b0;
            cnt        <= CW'(SETTLE - 1);
            retry      <= '0;
            busy       <= 1'b1;
            state      <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (cnt == '0) begin
            sync_wr_en <= 1'b1;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (rd_match || retry == RW'(MAX_RETRY)) begin
            ack   <= NUM_REQ'(1) << grant_id;
            err   <= !rd_match;
            ptr   <= ptr_next;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            retry      <= retry + 1'b1;
            sync_wr_en <= 1'b0;
            cnt        <= CW'(SETTLE - 1);
            state      <= ST_FLUSH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  logic unused_rdback;

  assign unused_rdback = ^sync_rdback;
  assign can_grant     = gnt_valid;
  assign err           = 1'b0;

  always_ff @(posedge clk_clkin) begin
    if (reset) begin
      state      <= ST_IDLE;
      sync_data  <= '0;
      sync_wr_en <= 1'b1;
      ack        <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      ptr        <= '0;
      cnt        <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          sync_wr_en <= 1'b1;
          if (can_grant) begin
            grant_id   <= gnt_idx;
            sync_data  <= sel_word;
            sync_wr_en <= 1'b0;
            cnt        <= CW'(SETTLE - 1);
            busy       <= 1'b1;
            state      <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (cnt == '0) begin
            sync_wr_en <= 1'b1;
            ack        <= NUM_REQ'(1) << grant_id;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          ptr   <= ptr_next;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`endif

endmodule
